// File: rtl/core_defs.sv
// Shared definitions for the core pipeline: widths, RAM size codes,
// write-back FSM states and the instruction record WB holds.
package core_defs;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  // RAM access size encodings (3 also means word)
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RAM = 1'b1
  } wb_state_e;

  // Everything WB needs to commit one instruction later
  typedef struct packed {
    logic [REGW-1:0] rd;
    logic            write_rd;
    logic            load;
    logic [1:0]      size;
    logic            load_unsigned;
    logic [XLEN-1:0] pc;
    logic            jmp;
    logic            link;
    logic [XLEN-1:0] link_addr;
    logic [XLEN-1:0] value;
    logic            computed;
  } wb_instr_t;

endpackage

// File: rtl/core_wb_loadext.sv
// Load data size selection and sign/zero extension of right-aligned RAM data.
module core_wb_loadext
  import core_defs::*;
#(
  parameter int XLEN_P = core_defs::XLEN
) (
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [XLEN_P-1:0] din_i,
  output logic [XLEN_P-1:0] dout_o
);

  // Byte/half are extended from the low bits; word sizes pass through
  always_comb begin
    dout_o = din_i;
    case (size_i)
      SZ_BYTE: dout_o = unsigned_i ? {{(XLEN_P-8){1'b0}}, din_i[7:0]}
                                   : {{(XLEN_P-8){din_i[7]}}, din_i[7:0]};
      SZ_HALF: dout_o = unsigned_i ? {{(XLEN_P-16){1'b0}}, din_i[15:0]}
                                   : {{(XLEN_P-16){din_i[15]}}, din_i[15:0]};
      default: dout_o = din_i;
    endcase
  end

endmodule

// File: rtl/core_pipe_wb.sv
// Write-back stage: waits for load data, picks the write-back value and
// drives the register-file write port and PC redirect. A one-entry pending
// slot catches the instruction MEM may launch as WB starts waiting on a load.
module core_pipe_wb
  import core_defs::*;
#(
  parameter int XLEN = core_defs::XLEN,
  parameter int REGW = core_defs::REGW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_validout,
  output logic            wb_allowin,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_write_rd,
  input  logic            mem_result_mem_load,
  input  logic [1:0]      mem_ram_size,
  input  logic            mem_load_unsigned,
  input  logic [XLEN-1:0] mem_result_pc,
  input  logic            mem_result_jmp,
  input  logic            mem_result_link,
  input  logic [XLEN-1:0] mem_result_link_addr,
  input  logic [XLEN-1:0] mem_result_value,
  input  logic            mem_result_computed,
  input  logic            ram_done,
  input  logic [XLEN-1:0] ram_dout,
  output logic            wb_reg_we,
  output logic [REGW-1:0] wb_reg_waddr,
  output logic [XLEN-1:0] wb_reg_wdata,
  output logic            wb_pc_redirect,
  output logic [XLEN-1:0] wb_pc_target,
  output logic            wb_retire,
  output logic            wb_busy,
  output logic [REGW-1:0] wb_busy_rd,
  output logic            wb_overflow
);

  wb_state_e       state_q, state_d;
  wb_instr_t       held_q, held_d;
  wb_instr_t       slot_q, slot_d;
  logic            slot_valid_q, slot_valid_d;
  logic            overflow_q, overflow_d;
  logic            allowin_q, we_q, redirect_q, retire_q, busy_q;
  logic [REGW-1:0] waddr_q, busy_rd_q;
  logic [XLEN-1:0] wdata_q, target_q;

  wb_instr_t       in_instr, arr, commit_in;
  logic            arr_valid, commit, write_en;
  logic [XLEN-1:0] ext_data, wb_data;

  // Pack the MEM-stage fields into one record
  always_comb begin
    in_instr               = '0;
    in_instr.rd            = mem_rd;
    in_instr.write_rd      = mem_write_rd;
    in_instr.load          = mem_result_mem_load;
    in_instr.size          = mem_ram_size;
    in_instr.load_unsigned = mem_load_unsigned;
    in_instr.pc            = mem_result_pc;
    in_instr.jmp           = mem_result_jmp;
    in_instr.link          = mem_result_link;
    in_instr.link_addr     = mem_result_link_addr;
    in_instr.value         = mem_result_value;
    in_instr.computed      = mem_result_computed;
  end

  // Next-state: accept/commit in IDLE (pending slot first), wait for load data in WAIT_RAM
  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    overflow_d   = overflow_q;
    commit       = 1'b0;
    commit_in    = held_q;
    arr          = in_instr;
    arr_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        // A held slot is replayed as a fresh arrival; MEM should be stalled
        arr_valid    = slot_valid_q | mem_validout;
        arr          = slot_valid_q ? slot_q : in_instr;
        slot_valid_d = 1'b0;
        if (slot_valid_q && mem_validout) overflow_d = 1'b1;
        if (arr_valid) begin
          if (!arr.load || ram_done) begin
            commit    = 1'b1;
            commit_in = arr;
          end else begin
            held_d  = arr;
            state_d = WAIT_RAM;
          end
        end
      end
      WAIT_RAM: begin
        if (mem_validout) begin
          if (!slot_valid_q) begin
            slot_d       = in_instr;
            slot_valid_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (ram_done) begin
          commit    = 1'b1;
          commit_in = held_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  core_wb_loadext #(.XLEN_P(XLEN)) u_loadext (
    .size_i     (commit_in.size),
    .unsigned_i (commit_in.load_unsigned),
    .din_i      (ram_dout),
    .dout_o     (ext_data)
  );

  // Write-back value (load > link > computed) and x0 suppression
  always_comb begin
    write_en = (commit_in.rd != '0) &&
               ((commit_in.load && commit_in.write_rd) || commit_in.link || commit_in.computed);
    if (commit_in.load)      wb_data = ext_data;
    else if (commit_in.link) wb_data = commit_in.link_addr;
    else                     wb_data = commit_in.value;
  end

  // State, slot and registered commit outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      held_q       <= '0;
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      allowin_q    <= 1'b1;
      we_q         <= 1'b0;
      redirect_q   <= 1'b0;
      retire_q     <= 1'b0;
      busy_q       <= 1'b0;
      waddr_q      <= '0;
      busy_rd_q    <= '0;
      wdata_q      <= '0;
      target_q     <= '0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      overflow_q   <= overflow_d;
      allowin_q    <= (state_d == IDLE) && !slot_valid_d;
      we_q         <= commit && write_en;
      redirect_q   <= commit && commit_in.jmp;
      retire_q     <= commit;
      busy_q       <= (state_d == WAIT_RAM);
      busy_rd_q    <= (state_d == WAIT_RAM) ? held_d.rd : '0;
      if (commit && write_en) begin
        waddr_q <= commit_in.rd;
        wdata_q <= wb_data;
      end
      if (commit && commit_in.jmp) target_q <= commit_in.pc;
    end
  end

  assign wb_allowin     = allowin_q;
  assign wb_reg_we      = we_q;
  assign wb_reg_waddr   = waddr_q;
  assign wb_reg_wdata   = wdata_q;
  assign wb_pc_redirect = redirect_q;
  assign wb_pc_target   = target_q;
  assign wb_retire      = retire_q;
  assign wb_busy        = busy_q;
  assign wb_busy_rd     = busy_rd_q;
  assign wb_overflow    = overflow_q;

endmodule

// File: tb/tb_core_pipe_wb.sv
// Directed bench for core_pipe_wb: ALU, JAL, loads with delayed and
// same-cycle data, pending slot, overflow, x0 writes and reset mid-load.
module tb_core_pipe_wb;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mem_validout;
  logic            wb_allowin;
  logic [REGW-1:0] mem_rd;
  logic            mem_write_rd;
  logic            mem_result_mem_load;
  logic [1:0]      mem_ram_size;
  logic            mem_load_unsigned;
  logic [XLEN-1:0] mem_result_pc;
  logic            mem_result_jmp;
  logic            mem_result_link;
  logic [XLEN-1:0] mem_result_link_addr;
  logic [XLEN-1:0] mem_result_value;
  logic            mem_result_computed;
  logic            ram_done;
  logic [XLEN-1:0] ram_dout;
  logic            wb_reg_we;
  logic [REGW-1:0] wb_reg_waddr;
  logic [XLEN-1:0] wb_reg_wdata;
  logic            wb_pc_redirect;
  logic [XLEN-1:0] wb_pc_target;
  logic            wb_retire;
  logic            wb_busy;
  logic [REGW-1:0] wb_busy_rd;
  logic            wb_overflow;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  core_pipe_wb #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .mem_validout         (mem_validout),
    .wb_allowin           (wb_allowin),
    .mem_rd               (mem_rd),
    .mem_write_rd         (mem_write_rd),
    .mem_result_mem_load  (mem_result_mem_load),
    .mem_ram_size         (mem_ram_size),
    .mem_load_unsigned    (mem_load_unsigned),
    .mem_result_pc        (mem_result_pc),
    .mem_result_jmp       (mem_result_jmp),
    .mem_result_link      (mem_result_link),
    .mem_result_link_addr (mem_result_link_addr),
    .mem_result_value     (mem_result_value),
    .mem_result_computed  (mem_result_computed),
    .ram_done             (ram_done),
    .ram_dout             (ram_dout),
    .wb_reg_we            (wb_reg_we),
    .wb_reg_waddr         (wb_reg_waddr),
    .wb_reg_wdata         (wb_reg_wdata),
    .wb_pc_redirect       (wb_pc_redirect),
    .wb_pc_target         (wb_pc_target),
    .wb_retire            (wb_retire),
    .wb_busy              (wb_busy),
    .wb_busy_rd           (wb_busy_rd),
    .wb_overflow          (wb_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mem_validout = 0; mem_rd = '0; mem_write_rd = 0; mem_result_mem_load = 0;
    mem_ram_size = 2'd0; mem_load_unsigned = 0; mem_result_pc = '0;
    mem_result_jmp = 0; mem_result_link = 0; mem_result_link_addr = '0;
    mem_result_value = '0; mem_result_computed = 0; ram_done = 0; ram_dout = '0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] val);
    clr();
    mem_validout = 1; mem_rd = rd; mem_result_value = val; mem_result_computed = 1;
  endtask

  task automatic load(input logic [4:0] rd, input logic [1:0] sz, input logic uns);
    clr();
    mem_validout = 1; mem_rd = rd; mem_result_mem_load = 1; mem_write_rd = 1;
    mem_ram_size = sz; mem_load_unsigned = uns;
  endtask

  initial begin
    clr();
    rst_n = 0;
    tick(); tick();
    // reset values
    chk("rst_allowin", 32'(wb_allowin), 1);
    chk("rst_we", 32'(wb_reg_we), 0);
    chk("rst_retire", 32'(wb_retire), 0);
    chk("rst_redirect", 32'(wb_pc_redirect), 0);
    chk("rst_busy", 32'(wb_busy), 0);
    chk("rst_ovf", 32'(wb_overflow), 0);
    chk("rst_waddr", 32'(wb_reg_waddr), 0);
    chk("rst_wdata", wb_reg_wdata, 0);
    chk("rst_target", wb_pc_target, 0);
    chk("rst_busy_rd", 32'(wb_busy_rd), 0);
    rst_n = 1;
    tick();

    // ALU op commits in N+1
    alu(5'd5, 32'h1234);
    tick();
    chk("alu_we", 32'(wb_reg_we), 1);
    chk("alu_waddr", 32'(wb_reg_waddr), 5);
    chk("alu_wdata", wb_reg_wdata, 32'h1234);
    chk("alu_retire", 32'(wb_retire), 1);
    // back-to-back ALU: one per cycle
    alu(5'd6, 32'hABCD);
    tick();
    chk("alu2_waddr", 32'(wb_reg_waddr), 6);
    chk("alu2_wdata", wb_reg_wdata, 32'hABCD);
    chk("alu2_retire", 32'(wb_retire), 1);
    clr();
    tick();
    chk("idle_we", 32'(wb_reg_we), 0);
    chk("idle_retire", 32'(wb_retire), 0);

    // JAL: link write plus redirect in the same cycle
    clr();
    mem_validout = 1; mem_rd = 5'd1; mem_result_link = 1; mem_result_link_addr = 32'h104;
    mem_result_jmp = 1; mem_result_pc = 32'h200; mem_result_value = 32'hDEAD;
    tick();
    chk("jal_we", 32'(wb_reg_we), 1);
    chk("jal_waddr", 32'(wb_reg_waddr), 1);
    chk("jal_wdata", wb_reg_wdata, 32'h104);
    chk("jal_redirect", 32'(wb_pc_redirect), 1);
    chk("jal_target", wb_pc_target, 32'h200);
    clr();
    tick();
    chk("jal_redirect_pulse", 32'(wb_pc_redirect), 0);

    // LB rd=3, data arrives 3 cycles later
    load(5'd3, 2'd0, 1'b0);
    tick();
    clr();
    chk("lb_busy", 32'(wb_busy), 1);
    chk("lb_busy_rd", 32'(wb_busy_rd), 3);
    chk("lb_allowin", 32'(wb_allowin), 0);
    chk("lb_we_wait", 32'(wb_reg_we), 0);
    tick();
    chk("lb_busy2", 32'(wb_busy), 1);
    tick();
    ram_done = 1; ram_dout = 32'h000000F0;
    tick();
    clr();
    chk("lb_we", 32'(wb_reg_we), 1);
    chk("lb_waddr", 32'(wb_reg_waddr), 3);
    chk("lb_wdata", wb_reg_wdata, 32'hFFFFFFF0);
    chk("lb_retire", 32'(wb_retire), 1);
    chk("lb_busy_done", 32'(wb_busy), 0);
    tick();
    chk("lb_allowin_back", 32'(wb_allowin), 1);

    // LHU rd=7, data one cycle later
    load(5'd7, 2'd1, 1'b1);
    tick();
    clr();
    chk("lhu_busy_rd", 32'(wb_busy_rd), 7);
    ram_done = 1; ram_dout = 32'hFFFF8001;
    tick();
    clr();
    chk("lhu_wdata", wb_reg_wdata, 32'h00008001);
    chk("lhu_waddr", 32'(wb_reg_waddr), 7);

    // LW with same-cycle ram_done: commit N+1, allowin stays high
    load(5'd9, 2'd2, 1'b0);
    ram_done = 1; ram_dout = 32'hCAFEBABE;
    tick();
    chk("lw_now_allowin", 32'(wb_allowin), 1);
    chk("lw_now_busy", 32'(wb_busy), 0);
    chk("lw_now_wdata", wb_reg_wdata, 32'hCAFEBABE);
    chk("lw_now_waddr", 32'(wb_reg_waddr), 9);
    // LH signed, same cycle
    load(5'd10, 2'd1, 1'b0);
    ram_done = 1; ram_dout = 32'h12348001;
    tick();
    chk("lh_now_wdata", wb_reg_wdata, 32'hFFFF8001);
    chk("lh_now_allowin", 32'(wb_allowin), 1);
    clr();
    tick();

    // Load waiting, ALU into pending slot, third arrival overflows
    load(5'd4, 2'd0, 1'b1);
    tick();
    alu(5'd6, 32'h55);
    tick();
    clr();
    chk("slot_ovf0", 32'(wb_overflow), 0);
    chk("slot_allowin", 32'(wb_allowin), 0);
    chk("slot_we_wait", 32'(wb_reg_we), 0);
    alu(5'd8, 32'h77);
    tick();
    clr();
    chk("slot_ovf1", 32'(wb_overflow), 1);
    ram_done = 1; ram_dout = 32'h000001A5;
    tick();
    clr();
    chk("slot_ld_we", 32'(wb_reg_we), 1);
    chk("slot_ld_waddr", 32'(wb_reg_waddr), 4);
    chk("slot_ld_wdata", wb_reg_wdata, 32'hA5);
    tick();
    chk("slot_alu_we", 32'(wb_reg_we), 1);
    chk("slot_alu_waddr", 32'(wb_reg_waddr), 6);
    chk("slot_alu_wdata", wb_reg_wdata, 32'h55);
    chk("slot_alu_retire", 32'(wb_retire), 1);
    tick();
    chk("slot_done_retire", 32'(wb_retire), 0);
    chk("slot_done_allowin", 32'(wb_allowin), 1);
    chk("ovf_sticky", 32'(wb_overflow), 1);

    // rd=0 computed op retires without a write
    alu(5'd0, 32'h999);
    tick();
    clr();
    chk("x0_we", 32'(wb_reg_we), 0);
    chk("x0_retire", 32'(wb_retire), 1);
    chk("x0_wdata_kept", wb_reg_wdata, 32'h55);

    // Reset in WAIT_RAM, then a late ram_done
    load(5'd11, 2'd2, 1'b0);
    tick();
    clr();
    chk("rstw_busy", 32'(wb_busy), 1);
    rst_n = 0;
    tick();
    chk("rstw_allowin", 32'(wb_allowin), 1);
    chk("rstw_busy0", 32'(wb_busy), 0);
    chk("rstw_busy_rd", 32'(wb_busy_rd), 0);
    chk("rstw_ovf", 32'(wb_overflow), 0);
    chk("rstw_waddr", 32'(wb_reg_waddr), 0);
    chk("rstw_wdata", wb_reg_wdata, 0);
    rst_n = 1;
    ram_done = 1; ram_dout = 32'h12345678;
    tick();
    clr();
    chk("late_done_we", 32'(wb_reg_we), 0);
    chk("late_done_retire", 32'(wb_retire), 0);
    chk("late_done_wdata", wb_reg_wdata, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
